// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift window,
// emitting one registered window per accepted pixel once a full neighbourhood exists.
module conv_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic signed [DATA_WIDTH-1:0] pixel_in,
  input  logic                        pixel_valid,
  input  logic                        sof,
  output logic [9*DATA_WIDTH-1:0]     window_out,
  output logic                        window_valid,
  output logic [7:0]                  out_row,
  output logic [7:0]                  out_col,
  output logic                        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  // Handshake: a pixel is consumed on any rising edge where enable & pixel_valid;
  // there is no ready, so every window_valid strobe must be taken by the consumer.
  logic acc;
  assign acc = enable & pixel_valid;

  logic [CW-1:0] col_q, col_d, eff_col;
  logic [RW-1:0] row_q, row_d, eff_row;

  logic [DATA_WIDTH-1:0] lb0_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

  logic [8:0][DATA_WIDTH-1:0] win_q, win_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;
  logic [7:0]                 out_row_q, out_row_d;
  logic [7:0]                 out_col_q, out_col_d;

  // sof forces the accepted pixel to (0,0) regardless of where the counters were.
  always_comb begin
    eff_col = sof ? '0 : col_q;
    eff_row = sof ? '0 : row_q;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (eff_col == LAST_COL) begin
        col_d = '0;
        row_d = (eff_row == LAST_ROW) ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
    end else if (enable && sof) begin
      col_d = '0;
      row_d = '0;
    end
  end

  assign lb0_rd = lb0_mem[eff_col];
  assign lb1_rd = lb1_mem[eff_col];

  // Contents are only ever consumed after being rewritten in the current frame, so no reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0_mem[eff_col] <= lb1_rd;
      lb1_mem[eff_col] <= pixel_in;
    end
  end

  always_comb begin
    win_d     = win_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    if (acc) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb0_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pixel_in;
      // Columns 0..1 of a fresh row have shifted stale data out by the time c reaches 2.
      if (eff_row >= RW'(2) && eff_col >= CW'(2)) begin
        valid_d   = 1'b1;
        out_row_d = 8'(eff_row) - 8'd2;
        out_col_d = 8'(eff_col) - 8'd2;
        done_d    = (eff_row == LAST_ROW) && (eff_col == LAST_COL);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      win_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_q     <= win_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
    end
  end

  assign window_out   = win_q;
  assign window_valid = valid_q;
  assign frame_done   = done_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on a 5x4 image: a frame-memory model pushes expected
// windows with their due cycle; a negedge monitor pops and compares them.
module tb_conv_window_gen;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WW = 9 * DW;
  localparam int EW = 32 + 1 + 8 + 8 + WW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable;
  logic signed [DW-1:0] pixel_in;
  logic                 pixel_valid;
  logic                 sof;
  logic [WW-1:0]        window_out;
  logic                 window_valid;
  logic [7:0]           out_row;
  logic [7:0]           out_col;
  logic                 frame_done;

  conv_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .sof(sof), .window_out(window_out),
    .window_valid(window_valid), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  logic en_edge = 1'b1;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_edge <= enable;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] img [H][W];
  int mr = 0;
  int mc = 0;

  logic [WW-1:0] obs_win[$];
  int            fd_count = 0;
  logic [WW-1:0] fd_win   = '0;

  function automatic logic [WW-1:0] pack_ramp(input int b);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(b + (k / 3) * W + (k % 3));
    return w;
  endfunction

  task automatic model_accept(input int v, input bit s);
    logic [WW-1:0] w;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = DW'(v);
    if (mr >= 2 && mc >= 2) begin
      for (int k = 0; k < 9; k++) w[k*DW +: DW] = img[mr-2+k/3][mc-2+k%3];
      exp_q.push_back({32'(cyc), (mr == H-1 && mc == W-1), 8'(mr-2), 8'(mc-2), w});
    end
    if (mc == W-1) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (!en_edge) check("valid_while_disabled", window_valid, 0);
      if (window_valid) begin
        obs_win.push_back(window_out);
        if (frame_done) begin
          fd_count++;
          fd_win = window_out;
        end
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("window", window_out, e[WW-1:0]);
          check("out_col", out_col, e[WW+7:WW]);
          check("out_row", out_row, e[WW+15:WW+8]);
          check("frame_done", frame_done, e[WW+16]);
          check("latency_cycle", cyc, e[WW+48:WW+17]);
        end
      end else begin
        check("frame_done_no_valid", frame_done, 0);
        if (exp_q.size() != 0 && int'(exp_q[0][WW+48:WW+17]) <= cyc) begin
          e = exp_q.pop_front();
          check("missing_valid", 0, 1);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input int v, input bit s);
    pixel_in    = DW'(v);
    sof         = s;
    pixel_valid = 1'b1;
    @(posedge clk);
    #1;
    if (enable) model_accept(v, s);
    pixel_valid = 1'b0;
    sof         = 1'b0;
  endtask

  task automatic gap(input int n);
    pixel_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ramp(input int base, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      send(base + i, i == 0);
      if (gaps) begin
        gap($urandom_range(0, 3));
        if (i == 7) begin
          enable      = 1'b0;
          pixel_valid = 1'b1;
          pixel_in    = 8'sd99;
          repeat (5) @(posedge clk);
          #1;
          pixel_valid = 1'b0;
          enable      = 1'b1;
        end
      end
    end
  endtask

  task automatic begin_frame();
    obs_win.delete();
    fd_count = 0;
    fd_win   = '0;
  endtask

  task automatic check_ramp_frame(input string tag, input int base);
    check({tag, "_count"}, obs_win.size(), 6);
    check({tag, "_fd_count"}, fd_count, 1);
    check({tag, "_fd_window"}, fd_win, pack_ramp(base + 7));
    if (obs_win.size() == 6) begin
      check({tag, "_first"}, obs_win[0], pack_ramp(base));
      check({tag, "_last"}, obs_win[5], pack_ramp(base + 7));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_window"}, window_out, 0);
    check({tag, "_valid"}, window_valid, 0);
    check({tag, "_row"}, out_row, 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_fd"}, frame_done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    pixel_in    = '0;
    #3;
    check_zero_outputs("reset0");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(2);

    // continuous ramp
    begin_frame();
    ramp(0, 20, 1'b0);
    gap(3);
    check_ramp_frame("ramp", 0);

    // gaps plus enable drop mid-row
    begin_frame();
    ramp(0, 20, 1'b1);
    gap(3);
    check_ramp_frame("gaps", 0);

    // back-to-back frames, no idle between
    begin_frame();
    ramp(0, 20, 1'b0);
    ramp(100, 20, 1'b0);
    gap(3);
    check("b2b_count", obs_win.size(), 12);
    if (obs_win.size() == 12) check("b2b_second_first", obs_win[6], pack_ramp(100));

    // reset mid-frame after pixel 8
    begin_frame();
    ramp(0, 9, 1'b0);
    rst_n = 1'b0;
    #2;
    check_zero_outputs("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset_hold");
    exp_q.delete();
    mr = 0;
    mc = 0;
    rst_n = 1'b1;
    gap(1);
    begin_frame();
    ramp(0, 20, 1'b0);
    gap(3);
    check_ramp_frame("after_reset", 0);

    // sof with value 50 at position (1,3)
    begin_frame();
    ramp(0, 8, 1'b0);
    send(50, 1'b1);
    for (int i = 51; i <= 69; i++) send(i, 1'b0);
    gap(3);
    check_ramp_frame("sof_mid", 50);

    // sof without pixel_valid clears counters, next frame carries no sof
    begin_frame();
    ramp(0, 7, 1'b0);
    sof = 1'b1;
    @(posedge clk);
    #1;
    sof = 1'b0;
    mr  = 0;
    mc  = 0;
    for (int i = 0; i < 20; i++) send(200 + i, 1'b0);
    gap(3);
    check_ramp_frame("sof_only", 200);

    // random signed data with random gaps
    begin_frame();
    for (int i = 0; i < 20; i++) begin
      send($urandom_range(0, 255), i == 0);
      gap($urandom_range(0, 2));
    end
    gap(3);
    check("rand_count", obs_win.size(), 6);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
